touch_led_ctrl: RTL and testbench
=================================

Name: touch_led_ctrl

Overview:
Gesture-driven LED mode controller for the touch-key/LED path. The touch_key input is asynchronous. The block synchronises and debounces it, then classifies each press as a short tap or a long press. A three-state mode FSM sequences the LED between off, steady on and blinking. It sits between the touch pad pin and the board LED, in place of direct toggle logic.

Parameters:
DEBOUNCE_CYC, 1_000_000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be >= 1.
LONG_CYC, 50_000_000, cycles of debounced hold that make a press "long" (1 s); must be > 1.
BLINK_HALF_CYC, 12_500_000, cycles per LED half-period in BLINK mode (250 ms); must be >= 1.

Ports:
sys_clk     input   1  system clock, 50 MHz, all logic on rising edge
sys_rst     input   1  asynchronous, active-high reset
touch_key   input   1  raw touch pad output, asynchronous, 1 = touched
led         output  1  LED drive, 1 = lit, registered
mode        output  2  current mode: 0 = OFF, 1 = ON, 2 = BLINK (3 never produced)
tap_pulse   output  1  one-cycle strobe on classified short tap
long_pulse  output  1  one-cycle strobe when a press reaches LONG_CYC

Behaviour:
- Reset (async assert, synchronous release): sync flops = 0, key_stable = 0, debounce/hold/blink counters = 0, press FSM = IDLE, mode = OFF, led = 0, tap_pulse = 0, long_pulse = 0.
- Synchroniser: 2-flop chain on touch_key. Output is key_sync.
- Debounce:
  - When key_sync != key_stable, the counter increments; it resets to 0 on any cycle with key_sync == key_stable.
  - When the counter reaches DEBOUNCE_CYC-1 while still differing, key_stable flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles are ignored.
  - Counter width is $clog2(DEBOUNCE_CYC+1).
- Edge detect: rise/fall are single-cycle pulses from registered key_stable.
- Press FSM, states IDLE, PRESS, HELD:
  - IDLE: on rise, go to PRESS and set hold_cnt = 0.
  - PRESS: hold_cnt increments each cycle.
    - Fall before hold_cnt reaches LONG_CYC-1: assert tap_pulse next cycle, go to IDLE.
    - hold_cnt == LONG_CYC-1: assert long_pulse next cycle, go to HELD. Fall on that same cycle still counts as long.
  - HELD: wait for fall, then go to IDLE with no pulse.
  - hold_cnt saturates and never wraps.
  - A rise in PRESS or HELD is impossible by construction and is ignored.
- Mode FSM (registered; updates the cycle after the pulse):
  - tap: OFF->ON, ON->OFF, BLINK->OFF.
  - long: OFF->BLINK, ON->BLINK, BLINK->ON.
  - tap and long are mutually exclusive by construction. If both are ever asserted, long wins.
- LED:
  - OFF: led = 0.
  - ON: led = 1.
  - BLINK:
    - On entry, blink_cnt = 0 and phase = 1.
    - blink_cnt counts 0..BLINK_HALF_CYC-1. On the terminal count, phase toggles and the counter clears.
    - led = phase.
  - On leaving BLINK, blink_cnt clears.
  - led is registered and lags mode by 1 cycle.
- Latency:
  - touch_key edge to key_stable: 2 sync cycles + DEBOUNCE_CYC cycles.
  - key_stable fall to tap_pulse: 2 cycles.
  - tap_pulse to mode: 1 cycle; mode to led: 1 cycle.
- Reset mid-press or mid-blink: everything returns to reset values immediately. No pulse is emitted on release.
- A touch held across reset release is seen as a fresh rise after debounce.

Decomposition:
- touch_led_pkg: mode encodings (MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2) and press-state encodings (P_IDLE, P_PRESS, P_HELD).
- One sub-module, key_debounce: contains the synchroniser and debounce counter.
  - Parameter: DEBOUNCE_CYC.
  - Ports: sys_clk, sys_rst, key_in, key_stable, key_rise, key_fall.
- Press FSM, mode FSM and blink generator stay in touch_led_ctrl.

Test Plan:
Bench parameters: DEBOUNCE_CYC = 4, LONG_CYC = 50, BLINK_HALF_CYC = 8, 20 ns clock, sys_rst high for 200 ns.
1. Glitch reject: 3-cycle high pulses on touch_key -> key_stable stays 0, tap_pulse never asserts, mode = 0, led = 0.
2. Short tap: hold 20 cycles, release -> exactly one tap_pulse, mode = 1, led = 1. Repeat the tap -> mode = 0, led = 0.
3. Long press from OFF: hold 80 cycles -> one long_pulse about 50 cycles after key_stable rises, then mode = 2. led = 1 for 8 cycles, 0 for 8 cycles, repeating. Release emits no tap_pulse.
4. Long press from BLINK -> mode = 1, led = 1 steady. Short tap from BLINK (re-enter via long press first) -> mode = 0.
5. Boundary: hold with key_stable high for exactly 49 cycles -> tap. Hold for 50 cycles -> long_pulse, no tap.
6. Reset mid-operation: assert sys_rst during BLINK and again mid-press -> led, mode and pulses go to 0 asynchronously. A touch held through reset release is debounced and classified as a new press.

Source files
------------

// File: rtl/touch_led_pkg.sv
// Shared encodings for the touch-key LED controller: LED modes, press-classifier states
// and the gesture-to-mode transition rule.
package touch_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_PRESS = 2'd1,
    P_HELD  = 2'd2
  } press_e;

  // Long press takes priority if both gestures ever coincide.
  function automatic mode_e next_mode(input mode_e cur, input logic tap, input logic lng);
    mode_e nxt;
    nxt = cur;
    if (lng) begin
      nxt = (cur == MODE_BLINK) ? MODE_ON : MODE_BLINK;
    end else if (tap) begin
      nxt = (cur == MODE_OFF) ? MODE_ON : MODE_OFF;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce counter; key_stable follows key_in 2+DEBOUNCE_CYC cycles late.
// Registered one-cycle rise/fall strobes one cycle after key_stable changes; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_stable,
  output logic key_rise,
  output logic key_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync_q;
  logic          key_sync;
  logic          stable_d;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q     <= 1'b0;
      key_sync   <= 1'b0;
      key_stable <= 1'b0;
      stable_d   <= 1'b0;
      key_rise   <= 1'b0;
      key_fall   <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_q   <= key_in;
      key_sync <= sync_q;
      // Any cycle of agreement restarts the count, so short glitches never flip the level.
      if (key_sync != key_stable) begin
        if (db_cnt == CW'(DEBOUNCE_CYC - 1)) begin
          key_stable <= key_sync;
          db_cnt     <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      stable_d <= key_stable;
      key_rise <= key_stable & ~stable_d;
      key_fall <= ~key_stable & stable_d;
    end
  end

endmodule

// File: rtl/touch_led_ctrl.sv
// Touch gesture to LED mode controller: taps toggle OFF/ON, long presses enter/leave BLINK.
// key_stable fall to tap_pulse 2 cycles, pulse to mode 1 cycle, mode to led 1 cycle; no backpressure.
module touch_led_ctrl
  import touch_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1_000_000,
  parameter int LONG_CYC       = 50_000_000,
  parameter int BLINK_HALF_CYC = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       touch_key,
  output logic       led,
  output logic [1:0] mode,
  output logic       tap_pulse,
  output logic       long_pulse
);

  localparam int HW = $clog2(LONG_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF_CYC + 1);

  logic key_stable;
  logic key_rise;
  logic key_fall;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (touch_key),
    .key_stable(key_stable),
    .key_rise  (key_rise),
    .key_fall  (key_fall)
  );

  press_e          press_q, press_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            tap_d, long_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      press_q    <= P_IDLE;
      hold_q     <= '0;
      tap_pulse  <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      press_q    <= press_d;
      hold_q     <= hold_d;
      tap_pulse  <= tap_d;
      long_pulse <= long_d;
    end
  end

  always_comb begin
    press_d = press_q;
    hold_d  = hold_q;
    tap_d   = 1'b0;
    long_d  = 1'b0;
    case (press_q)
      P_IDLE: begin
        // A rise whose debounced level has already collapsed is not treated as a press.
        if (key_rise && key_stable) begin
          press_d = P_PRESS;
          hold_d  = '0;
        end
      end
      P_PRESS: begin
        if (hold_q == HW'(LONG_CYC - 1)) begin
          long_d  = 1'b1;
          press_d = key_fall ? P_IDLE : P_HELD;
        end else begin
          hold_d = hold_q + 1'b1;
          if (key_fall) begin
            tap_d   = 1'b1;
            press_d = P_IDLE;
          end
        end
      end
      P_HELD: begin
        if (key_fall) begin
          press_d = P_IDLE;
        end
      end
      default: press_d = P_IDLE;
    endcase
  end

  mode_e mode_q, mode_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = next_mode(mode_q, tap_pulse, long_pulse);
  end

  assign mode = mode_q;

  logic [BW-1:0] blink_cnt;
  logic          phase;

  // Outside BLINK the counter is held clear with phase high, so every entry starts lit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
      led       <= 1'b0;
    end else begin
      if (mode_q != MODE_BLINK) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_HALF_CYC - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      led <= (mode_q == MODE_ON) || ((mode_q == MODE_BLINK) && phase);
    end
  end

endmodule

// File: tb/tb_touch_led_ctrl.sv
// Directed bench for touch_led_ctrl: press-level model predicts pulses, mode and LED every cycle.
module tb_touch_led_ctrl;

  localparam int DB = 4;
  localparam int LC = 50;
  localparam int BH = 8;
  // Edge index (relative to the first edge that samples a touch_key change) at which key_stable follows.
  localparam int KEY_LAT = 2 + DB - 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       touch_key = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       tap_pulse;
  logic       long_pulse;

  touch_led_ctrl #(
    .DEBOUNCE_CYC  (DB),
    .LONG_CYC      (LC),
    .BLINK_HALF_CYC(BH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .touch_key (touch_key),
    .led       (led),
    .mode      (mode),
    .tap_pulse (tap_pulse),
    .long_pulse(long_pulse)
  );

  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int press_t = -1;
  int press_l = -1;
  int tap_cnt = 0;
  int long_cnt = 0;

  int exp_mode = 0;
  int nxt_mode;
  int blink_start = 0;
  int exp_led;
  bit exp_tap, exp_long;
  bit prev_tap = 0, prev_long = 0;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle model: a press sampled from edge T for L edges gives a tap at edge T+L+KEY_LAT+2
  // when DB <= L < LC, or a long pulse at edge T+KEY_LAT+2+LC when held at least LC.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      exp_mode  = 0;
      prev_tap  = 0;
      prev_long = 0;
    end else if (cyc >= 1) begin
      exp_tap  = (press_t >= 0) && (press_l >= DB) && (press_l < LC) &&
                 (cyc == press_t + press_l + KEY_LAT + 2);
      exp_long = (press_t >= 0) && (cyc == press_t + KEY_LAT + 2 + LC) &&
                 ((press_l < 0) || (press_l >= LC));
      case (exp_mode)
        1:       exp_led = 1;
        2:       exp_led = (((cyc - blink_start - 1) / BH) % 2 == 0) ? 1 : 0;
        default: exp_led = 0;
      endcase
      nxt_mode = exp_mode;
      if (prev_long)     nxt_mode = (exp_mode == 2) ? 1 : 2;
      else if (prev_tap) nxt_mode = (exp_mode == 0) ? 1 : 0;
      if (nxt_mode == 2 && exp_mode != 2) blink_start = cyc;
      exp_mode = nxt_mode;
      chk("tap_pulse", tap_pulse, exp_tap);
      chk("long_pulse", long_pulse, exp_long);
      chk("mode", mode, exp_mode);
      chk("led", led, exp_led);
      tap_cnt  += tap_pulse;
      long_cnt += long_pulse;
      prev_tap  = exp_tap;
      prev_long = exp_long;
    end
  end

  task automatic press(input int len, input int gap);
    @(negedge sys_clk);
    touch_key = 1'b1;
    press_t   = cyc + 1;
    press_l   = -1;
    repeat (len) @(negedge sys_clk);
    touch_key = 1'b0;
    press_l   = len;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_tap"}, tap_pulse, 0);
    chk({tag, "_long"}, long_pulse, 0);
  endtask

  initial begin
    int ones;
    repeat (5) @(negedge sys_clk);
    check_zero("reset");
    chk("reset_stable", dut.u_deb.key_stable, 0);
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    // Glitches shorter than the debounce window
    repeat (3) press(3, 12);
    chk("glitch_stable", dut.u_deb.key_stable, 0);
    chk("glitch_taps", tap_cnt, 0);
    chk("glitch_mode", mode, 0);
    chk("glitch_led", led, 0);

    // Tap toggles OFF -> ON -> OFF
    press(20, 20);
    chk("tap1_cnt", tap_cnt, 1);
    chk("tap1_mode", mode, 1);
    chk("tap1_led", led, 1);
    press(20, 20);
    chk("tap2_cnt", tap_cnt, 2);
    chk("tap2_mode", mode, 0);
    chk("tap2_led", led, 0);

    // Long press from OFF enters BLINK, release adds no tap
    press(80, 20);
    chk("long1_cnt", long_cnt, 1);
    chk("long1_taps", tap_cnt, 2);
    chk("long1_mode", mode, 2);
    ones = 0;
    repeat (2 * BH) begin
      @(negedge sys_clk);
      ones += led;
    end
    chk("blink_duty", ones, BH);

    // BLINK -> ON by long, ON -> BLINK by long, BLINK -> OFF by tap
    press(60, 20);
    chk("long2_mode", mode, 1);
    chk("long2_led", led, 1);
    chk("long2_cnt", long_cnt, 2);
    press(60, 20);
    chk("long3_mode", mode, 2);
    press(20, 20);
    chk("tap3_mode", mode, 0);
    chk("tap3_cnt", tap_cnt, 3);

    // Boundary: 49 cycles is a tap, 50 cycles is long
    press(LC - 1, 20);
    chk("b49_taps", tap_cnt, 4);
    chk("b49_longs", long_cnt, 3);
    chk("b49_mode", mode, 1);
    press(LC, 20);
    chk("b50_taps", tap_cnt, 4);
    chk("b50_longs", long_cnt, 4);
    chk("b50_mode", mode, 2);

    // Reset while blinking with the LED lit
    for (int i = 0; i < 4 * BH && led !== 1'b1; i++) @(negedge sys_clk);
    chk("pre_rst_led", led, 1);
    #3 sys_rst = 1'b1;
    press_t = -1;
    press_l = -1;
    #1 check_zero("rst_blink");
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("post_rst_mode", mode, 0);

    // Reset mid-press with the key held through release
    @(negedge sys_clk);
    touch_key = 1'b1;
    press_t   = cyc + 1;
    press_l   = -1;
    repeat (30) @(negedge sys_clk);
    #3 sys_rst = 1'b1;
    press_t = -1;
    #1 check_zero("rst_press");
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    press_t = cyc + 1;
    repeat (30) @(negedge sys_clk);
    touch_key = 1'b0;
    press_l   = cyc + 1 - press_t;
    repeat (20) @(negedge sys_clk);
    chk("held_thru_rst_mode", mode, 1);
    chk("held_thru_rst_led", led, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
